// File: rtl/axilite_reg_slave.sv
// AXI4-Lite slave exposing NUM_REGS 32-bit registers with byte strobes.
// Latency: B two cycles after a joint AW+W handshake, R one cycle after AR.
// Backpressure: one-entry AW/W holding regs; commits stall while a B response is unacknowledged.
module axilite_reg_slave #(
  parameter int                    ADDR_WIDTH  = 8,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    NUM_REGS    = 16,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = 32'h0
) (
  input  logic                           aclk,
  input  logic                           aresetn,
  // write address channel
  input  logic [ADDR_WIDTH-1:0]          awaddr,
  input  logic                           awvalid,
  output logic                           awready,
  // write data channel
  input  logic [DATA_WIDTH-1:0]          wdata,
  input  logic [DATA_WIDTH/8-1:0]        wstrb,
  input  logic                           wvalid,
  output logic                           wready,
  // write response channel
  output logic [1:0]                     bresp,
  output logic                           bvalid,
  input  logic                           bready,
  // read address channel
  input  logic [ADDR_WIDTH-1:0]          araddr,
  input  logic                           arvalid,
  output logic                           arready,
  // read data channel
  output logic [DATA_WIDTH-1:0]          rdata,
  output logic [1:0]                     rresp,
  output logic                           rvalid,
  input  logic                           rready,
  // register state
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o,
  output logic [NUM_REGS-1:0]            wr_pulse_o
);

  localparam int IDX_W  = ADDR_WIDTH - 2;
  localparam int STRB_W = DATA_WIDTH / 8;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // holding registers for the independently captured AW and W beats
  logic                   r_aw_full;
  logic [IDX_W-1:0]       r_aw_idx;
  logic                   r_w_full;
  logic [DATA_WIDTH-1:0]  r_w_data;
  logic [STRB_W-1:0]      r_w_strb;

  // response and register state
  logic                   r_bvalid;
  logic [1:0]             r_bresp;
  logic                   r_rvalid;
  logic [DATA_WIDTH-1:0]  r_rdata;
  logic [1:0]             r_rresp;
  logic [DATA_WIDTH-1:0]  r_regs [NUM_REGS];
  logic [NUM_REGS-1:0]    r_wr_pulse;

  logic                   w_aw_hs;
  logic                   w_w_hs;
  logic                   w_b_hs;
  logic                   w_ar_hs;
  logic                   w_r_hs;
  logic                   w_commit;
  logic [31:0]            w_wr_idx;
  logic [31:0]            w_rd_idx;
  logic                   w_wr_ok;
  logic                   w_rd_ok;
  logic [DATA_WIDTH-1:0]  w_rd_data;
  logic                   w_unused_addr_bits;

  // byte-offset bits of both addresses carry no meaning for word registers
  assign w_unused_addr_bits = ^{awaddr[1:0], araddr[1:0]};

  assign awready = !r_aw_full;
  assign wready  = !r_w_full;
  assign arready = !r_rvalid;
  assign bvalid  = r_bvalid;
  assign bresp   = r_bresp;
  assign rvalid  = r_rvalid;
  assign rdata   = r_rdata;
  assign rresp   = r_rresp;
  assign wr_pulse_o = r_wr_pulse;

  assign w_aw_hs = awvalid && !r_aw_full;
  assign w_w_hs  = wvalid && !r_w_full;
  assign w_b_hs  = r_bvalid && bready;
  assign w_ar_hs = arvalid && !r_rvalid;
  assign w_r_hs  = r_rvalid && rready;

  // a held write only lands once the previous response has been taken
  assign w_commit = r_aw_full && r_w_full && !r_bvalid;

  assign w_wr_idx = 32'(r_aw_idx);
  assign w_rd_idx = 32'(araddr[ADDR_WIDTH-1:2]);
  assign w_wr_ok  = (w_wr_idx < NUM_REGS);
  assign w_rd_ok  = (w_rd_idx < NUM_REGS);

  // read mux; out-of-range indices fall through to zero
  always_comb begin
    w_rd_data = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (w_rd_idx == 32'(i)) w_rd_data = r_regs[i];
    end
  end

  // AW holding register: filled on handshake, emptied on commit
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_aw_full <= 1'b0;
      r_aw_idx  <= '0;
    end else if (w_commit) begin
      r_aw_full <= 1'b0;
    end else if (w_aw_hs) begin
      r_aw_full <= 1'b1;
      r_aw_idx  <= awaddr[ADDR_WIDTH-1:2];
    end
  end

  // W holding register: filled on handshake, emptied on commit
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_w_full <= 1'b0;
      r_w_data <= '0;
      r_w_strb <= '0;
    end else if (w_commit) begin
      r_w_full <= 1'b0;
    end else if (w_w_hs) begin
      r_w_full <= 1'b1;
      r_w_data <= wdata;
      r_w_strb <= wstrb;
    end
  end

  // B channel: raised by commit, held with its response until accepted
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_bvalid <= 1'b0;
      r_bresp  <= RESP_OKAY;
    end else if (w_commit) begin
      r_bvalid <= 1'b1;
      r_bresp  <= w_wr_ok ? RESP_OKAY : RESP_SLVERR;
    end else if (w_b_hs) begin
      r_bvalid <= 1'b0;
    end
  end

  // register bank update with byte strobes, plus the one-cycle write pulse
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= RESET_VALUE;
      r_wr_pulse <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_wr_pulse[i] <= w_commit && (w_wr_idx == 32'(i));
        if (w_commit && (w_wr_idx == 32'(i))) begin
          for (int b = 0; b < STRB_W; b++) begin
            if (r_w_strb[b]) r_regs[i][8*b +: 8] <= r_w_data[8*b +: 8];
          end
        end
      end
    end
  end

  // R channel: samples the bank before any same-edge write lands
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_rresp  <= RESP_OKAY;
    end else if (w_ar_hs) begin
      r_rvalid <= 1'b1;
      r_rdata  <= w_rd_data;
      r_rresp  <= w_rd_ok ? RESP_OKAY : RESP_SLVERR;
    end else if (w_r_hs) begin
      r_rvalid <= 1'b0;
    end
  end

  // flat view of the bank, no extra pipeline
  for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_o
    assign regs_o[DATA_WIDTH*g +: DATA_WIDTH] = r_regs[g];
  end

endmodule

// File: tb/tb_axilite_reg_slave.sv
// Self-checking bench for axilite_reg_slave: vector table, timing sequences, random ops vs model.
// Latency: checks exact B/R cycle timing in the directed sequences.
// Backpressure: exercises held bready/rready and blocked AW while B is pending.
module tb_axilite_reg_slave;
  localparam int NR = 16;

  logic          aclk = 1'b0;
  logic          aresetn;
  logic [7:0]    awaddr;
  logic          awvalid;
  logic          awready;
  logic [31:0]   wdata;
  logic [3:0]    wstrb;
  logic          wvalid;
  logic          wready;
  logic [1:0]    bresp;
  logic          bvalid;
  logic          bready;
  logic [7:0]    araddr;
  logic          arvalid;
  logic          arready;
  logic [31:0]   rdata;
  logic [1:0]    rresp;
  logic          rvalid;
  logic          rready;
  logic [NR*32-1:0] regs_o;
  logic [NR-1:0] wr_pulse_o;

  always #5 aclk = ~aclk;

  axilite_reg_slave #(
    .ADDR_WIDTH(8), .DATA_WIDTH(32), .NUM_REGS(NR), .RESET_VALUE(32'h0)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .regs_o(regs_o), .wr_pulse_o(wr_pulse_o)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] model [NR];

  typedef struct {
    bit          is_wr;
    logic [7:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_resp;
  } vec_t;

  vec_t tbl [13];

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  function automatic void model_reset();
    for (int i = 0; i < NR; i++) model[i] = 32'h0;
  endfunction

  function automatic void model_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
    int idx;
    idx = int'(a[7:2]);
    if (idx < NR) begin
      for (int b = 0; b < 4; b++) if (s[b]) model[idx][8*b +: 8] = d[8*b +: 8];
    end
  endfunction

  function automatic logic [31:0] model_read(input logic [7:0] a);
    int idx;
    idx = int'(a[7:2]);
    return (idx < NR) ? model[idx] : 32'h0;
  endfunction

  function automatic logic [1:0] model_resp(input logic [7:0] a);
    return (int'(a[7:2]) < NR) ? 2'b00 : 2'b10;
  endfunction

  function automatic logic [NR*32-1:0] model_flat();
    logic [NR*32-1:0] f;
    for (int i = 0; i < NR; i++) f[32*i +: 32] = model[i];
    return f;
  endfunction

  // joint AW+W write; holds bready low for bdly cycles after bvalid rises
  task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int bdly, output logic [1:0] resp);
    bit aw_done = 0;
    bit w_done = 0;
    bit hs_aw;
    bit hs_w;
    int n = 0;
    logic [NR-1:0] exp_pulse;
    exp_pulse = (int'(a[7:2]) < NR) ? (NR'(1) << a[7:2]) : '0;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1; bready = 0;
    while (!(aw_done && w_done) && n < 50) begin
      hs_aw = awvalid && awready;
      hs_w  = wvalid && wready;
      step(); n++;
      if (hs_aw) begin aw_done = 1; awvalid = 0; end
      if (hs_w)  begin w_done = 1;  wvalid = 0; end
    end
    while (!bvalid && n < 50) begin step(); n++; end
    if (!bvalid) begin
      awvalid = 0; wvalid = 0;
      n_checks++; n_errors++;
      $display("FAIL write_timeout: no bvalid for addr %0h", a);
      resp = 2'bxx;
      return;
    end
    check("wr_pulse", wr_pulse_o, exp_pulse);
    resp = bresp;
    for (int k = 0; k < bdly; k++) begin
      step();
      check("b_hold", {bvalid, bresp}, {1'b1, resp});
    end
    bready = 1; step(); bready = 0;
    check("b_drop", bvalid, 1'b0);
    check("wr_pulse_clear", wr_pulse_o, '0);
  endtask

  // AR then R; rvalid must follow the AR handshake by exactly one cycle
  task automatic axi_read(input logic [7:0] a, input int rdly,
                          output logic [31:0] data, output logic [1:0] resp);
    int n = 0;
    bit hs = 0;
    araddr = a; arvalid = 1; rready = 0;
    while (!hs && n < 50) begin hs = arready; step(); n++; end
    arvalid = 0;
    if (!hs) begin
      n_checks++; n_errors++;
      $display("FAIL read_timeout: arready never high for addr %0h", a);
      data = 'x; resp = 'x;
      return;
    end
    check("r_latency", rvalid, 1'b1);
    data = rdata; resp = rresp;
    for (int k = 0; k < rdly; k++) begin
      step();
      check("r_hold", {rvalid, rresp, rdata}, {1'b1, resp, data});
    end
    rready = 1; step(); rready = 0;
    check("r_drop", rvalid, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0]  resp;
    logic [31:0] rd;
    logic [7:0]  a;
    logic [31:0] d;
    logic [3:0]  s;

    tbl[0]  = '{1'b0, 8'h04, 32'h0, 4'h0, 32'hDEADBEEF, 2'b00};
    tbl[1]  = '{1'b1, 8'h08, 32'hAAAAAAAA, 4'hF, 32'h0, 2'b00};
    tbl[2]  = '{1'b1, 8'h08, 32'h11223344, 4'h5, 32'h0, 2'b00};
    tbl[3]  = '{1'b0, 8'h0A, 32'h0, 4'h0, 32'hAA22AA44, 2'b00};
    tbl[4]  = '{1'b1, 8'h40, 32'h12345678, 4'hF, 32'h0, 2'b10};
    tbl[5]  = '{1'b0, 8'h40, 32'h0, 4'h0, 32'h0, 2'b10};
    tbl[6]  = '{1'b1, 8'h3C, 32'hFFFFFFFF, 4'h0, 32'h0, 2'b00};
    tbl[7]  = '{1'b0, 8'h3C, 32'h0, 4'h0, 32'h0, 2'b00};
    tbl[8]  = '{1'b1, 8'h3F, 32'hCAFEF00D, 4'hC, 32'h0, 2'b00};
    tbl[9]  = '{1'b0, 8'h3D, 32'h0, 4'h0, 32'hCAFE0000, 2'b00};
    tbl[10] = '{1'b0, 8'hFC, 32'h0, 4'h0, 32'h0, 2'b10};
    tbl[11] = '{1'b1, 8'h00, 32'h0000FFFF, 4'h3, 32'h0, 2'b00};
    tbl[12] = '{1'b0, 8'h01, 32'h0, 4'h0, 32'h0000FFFF, 2'b00};

    awaddr = 0; awvalid = 0; wdata = 0; wstrb = 0; wvalid = 0; bready = 0;
    araddr = 0; arvalid = 0; rready = 0;
    model_reset();

    // reset state
    aresetn = 1; #2; aresetn = 0; #2;
    check("rst_ready", {awready, wready, arready}, 3'b111);
    check("rst_valid", {bvalid, rvalid}, 2'b00);
    check("rst_resp_data", {bresp, rresp, rdata}, '0);
    check("rst_regs", regs_o, '0);
    check("rst_pulse", wr_pulse_o, '0);
    step(); step(); aresetn = 1; step();

    // joint AW+W: bvalid exactly two cycles later
    awaddr = 8'h04; wdata = 32'hDEADBEEF; wstrb = 4'hF; awvalid = 1; wvalid = 1; bready = 1;
    step(); awvalid = 0; wvalid = 0;
    check("lat_n1_bvalid", bvalid, 1'b0);
    step();
    check("lat_n2_bvalid", bvalid, 1'b1);
    check("lat_bresp", bresp, 2'b00);
    check("lat_reg1", regs_o[63:32], 32'hDEADBEEF);
    check("lat_pulse", wr_pulse_o, 16'h0002);
    step(); bready = 0;
    check("lat_bdrop", bvalid, 1'b0);
    check("lat_pulse_one_cycle", wr_pulse_o, 16'h0000);
    model_write(8'h04, 32'hDEADBEEF, 4'hF);

    // vector table
    for (int i = 0; i < 13; i++) begin
      if (tbl[i].is_wr) begin
        axi_write(tbl[i].addr, tbl[i].data, tbl[i].strb, i % 3, resp);
        check("tbl_bresp", resp, tbl[i].exp_resp);
        model_write(tbl[i].addr, tbl[i].data, tbl[i].strb);
      end else begin
        axi_read(tbl[i].addr, i % 2, rd, resp);
        check("tbl_rdata", rd, tbl[i].exp_rdata);
        check("tbl_rresp", resp, tbl[i].exp_resp);
      end
    end
    check("tbl_regs", regs_o, model_flat());

    // W three cycles ahead of AW
    axi_write(8'h08, 32'hAAAAAAAA, 4'hF, 0, resp);
    model_write(8'h08, 32'hAAAAAAAA, 4'hF);
    wdata = 32'h11223344; wstrb = 4'h5; wvalid = 1; bready = 1;
    step(); wvalid = 0;
    for (int k = 0; k < 3; k++) begin
      check("wfirst_wready_low", wready, 1'b0);
      check("wfirst_awready_high", awready, 1'b1);
      check("wfirst_no_b", bvalid, 1'b0);
      if (k == 2) begin awaddr = 8'h08; awvalid = 1; end
      step();
    end
    awvalid = 0;
    check("wfirst_held_no_b", bvalid, 1'b0);
    step();
    check("wfirst_bvalid", bvalid, 1'b1);
    check("wfirst_reg2", regs_o[95:64], 32'hAA22AA44);
    step(); bready = 0;
    check("wfirst_bdrop", bvalid, 1'b0);
    model_write(8'h08, 32'h11223344, 4'h5);

    // B stalled: one extra write held, third AW blocked
    awaddr = 8'h00; wdata = 32'h1; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    step(); awvalid = 0; wvalid = 0;
    step();
    check("stall_first_b", bvalid, 1'b1);
    check("stall_reg0_first", regs_o[31:0], 32'h1);
    wdata = 32'h2; awvalid = 1; wvalid = 1;
    check("stall_second_accept", {awready, wready}, 2'b11);
    step(); awvalid = 0; wvalid = 0;
    awaddr = 8'h04; awvalid = 1;
    for (int k = 0; k < 5; k++) begin
      check("stall_third_blocked", awready, 1'b0);
      check("stall_reg0_hold", regs_o[31:0], 32'h1);
      check("stall_b_hold", {bvalid, bresp}, 3'b100);
      step();
    end
    awvalid = 0; bready = 1;
    step(); bready = 0;
    check("stall_bdrop", bvalid, 1'b0);
    check("stall_reg0_pre", regs_o[31:0], 32'h1);
    step();
    check("stall_rebvalid", bvalid, 1'b1);
    check("stall_reg0_post", regs_o[31:0], 32'h2);
    check("stall_pulse", wr_pulse_o, 16'h0001);
    bready = 1; step(); bready = 0;
    check("stall_final_bdrop", bvalid, 1'b0);
    model_write(8'h00, 32'h1, 4'hF);
    model_write(8'h00, 32'h2, 4'hF);

    // read and write commit on the same edge: read sees the old value
    axi_write(8'h0C, 32'h1, 4'hF, 0, resp);
    model_write(8'h0C, 32'h1, 4'hF);
    awaddr = 8'h0C; wdata = 32'h5; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    step(); awvalid = 0; wvalid = 0;
    araddr = 8'h0C; arvalid = 1;
    check("same_edge_arready", arready, 1'b1);
    step(); arvalid = 0;
    check("same_edge_bvalid", bvalid, 1'b1);
    check("same_edge_reg3", regs_o[127:96], 32'h5);
    check("same_edge_rvalid", rvalid, 1'b1);
    check("same_edge_rdata_old", rdata, 32'h1);
    bready = 1; rready = 1; step(); bready = 0; rready = 0;
    model_write(8'h0C, 32'h5, 4'hF);
    axi_read(8'h0C, 0, rd, resp);
    check("same_edge_rdata_new", rd, 32'h5);

    // reset with W held and R pending
    wdata = 32'h77; wstrb = 4'hF; wvalid = 1;
    step(); wvalid = 0;
    araddr = 8'h0C; arvalid = 1;
    step(); arvalid = 0;
    check("rst_mid_pre", {wready, rvalid}, 2'b01);
    #2; aresetn = 0; #1;
    check("rst_mid_rvalid", rvalid, 1'b0);
    check("rst_mid_bvalid", bvalid, 1'b0);
    check("rst_mid_wready", wready, 1'b1);
    check("rst_mid_regs", regs_o, '0);
    check("rst_mid_rdata", rdata, 32'h0);
    model_reset();
    step(); step(); aresetn = 1; step();
    awaddr = 8'h00; awvalid = 1;
    check("rst_mid_awready", awready, 1'b1);
    step(); awvalid = 0;
    for (int k = 0; k < 4; k++) begin
      check("rst_mid_aw_alone_no_b", bvalid, 1'b0);
      step();
    end
    check("rst_mid_regs_after", regs_o, '0);
    aresetn = 0; step(); aresetn = 1; step();

    // random traffic against the reference model
    for (int i = 0; i < 150; i++) begin
      a = 8'($urandom_range(0, 8'h4F));
      d = $urandom;
      s = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) begin
        axi_write(a, d, s, $urandom_range(0, 2), resp);
        check("rnd_bresp", resp, model_resp(a));
        model_write(a, d, s);
      end else begin
        axi_read(a, $urandom_range(0, 2), rd, resp);
        check("rnd_rdata", rd, model_read(a));
        check("rnd_rresp", resp, model_resp(a));
      end
      check("rnd_regs", regs_o, model_flat());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
